seg_reader: RTL
===============

SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples required before a digit is captured.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 seg  input  7  segment pattern, active-low, seg[6]=a .. seg[0]=g.
REQ-005 an  input  4  digit select, active-low one-hot; an[i]=0 selects position i.
REQ-006 err_clr  input  1  synchronous clear of the sticky error flag.
REQ-007 digits  output  16  captured codes; position i occupies digits[4i+3:4i].
REQ-008 valid_mask  output  4  bit i set once position i has been captured since reset.
REQ-009 upd  output  1  one-cycle pulse on each capture.
REQ-010 upd_idx  output  2  position of the latest capture; holds its value between captures.
REQ-011 err  output  1  sticky flag indicating an invalid pattern was captured.

Function
REQ-012 Input stage: seg and an SHALL be registered each edge into the sample pair (S_an, S_seg), giving one cycle of input latency.
REQ-013 Decode table, S_seg to 4-bit code:
- 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
- 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
- 1111111 (blank)=4'hF; any other pattern=4'hE (invalid).
REQ-014 S_an is valid only when exactly one bit is 0; the position index is that bit's number.
REQ-015 FSM states: IDLE, TRACK, HELD; 8-bit counter cnt.
REQ-016 In any state, if the new sample pair differs from the previous pair: go to TRACK with cnt=1 when S_an is valid, otherwise go to IDLE with cnt=0.
REQ-017 IDLE with pair unchanged: remain in IDLE.
REQ-018 TRACK with pair unchanged: cnt increments.
REQ-019 TRACK capture: when cnt reaches STABLE_CYCLES, or immediately on entry when STABLE_CYCLES=1, the block SHALL on that edge:
- write the decoded code into the addressed position;
- set the matching valid_mask bit;
- load upd_idx;
- assert upd for exactly one cycle;
- go to HELD.
REQ-020 HELD with pair unchanged: no further capture and upd stays 0; a held pattern is captured exactly once.
REQ-021 Re-presentation: a pattern identical to the stored value SHALL still be captured and pulse upd when it reappears after any change of the pair.
REQ-022 Latency: a pair applied before edge k and held SHALL produce upd high in the cycle after edge k+STABLE_CYCLES.
REQ-023 Capture of code 4'hE SHALL set err; code 4'hF is legal and does not set err.
REQ-024 err SHALL clear on an edge where err_clr=1, except that a simultaneous set wins.
REQ-025 cnt SHALL saturate and never wrap; a capture is not retriggered by cnt overflow.
REQ-026 Positions not being captured SHALL hold their stored value.

Reset
REQ-027 rst=1 SHALL asynchronously force:
- digits=16'hFFFF, valid_mask=0, upd=0, upd_idx=0, err=0;
- state IDLE, cnt=0;
- S_an=4'hF, S_seg=7'h7F.
REQ-028 Asserting rst mid-TRACK SHALL abort the pending capture; after release, the pair must again be stable for STABLE_CYCLES samples before capture.
REQ-029 All outputs SHALL be registered and glitch-free.

Verification
REQ-030 STABLE_CYCLES=4; an=1110, seg=0010010 held 10 cycles:
- digits[3:0]=2, valid_mask=0001, upd_idx=0;
- exactly one upd pulse, five edges after application.
REQ-031 Scan an=0111 seg=1001111 (4 cycles), then an=1011 seg=0100100 (4 cycles), then an=1101 seg=0000000 (2 cycles):
- digits[15:12]=1, digits[11:8]=5;
- position 1 unchanged (4'hF);
- two upd pulses.
REQ-032 an=1100 (two bits low) held 20 cycles with any seg: no upd, state IDLE, outputs unchanged.
REQ-033 an=1110, seg=1010101 held 6 cycles:
- digits[3:0]=E, err=1;
- err_clr=1 in a later cycle with no capture gives err=0;
- err_clr on the same edge as another invalid capture leaves err=1.
REQ-034 Stability and reset timing:
- seg toggles between 0000001 and 0000110 every 3 cycles: no capture;
- rst pulsed after 3 stable cycles: outputs at reset values, with capture only after 4 further stable samples.

Source files
------------

// File: rtl/seg_reader.sv
// Seven-segment scan reader: samples a multiplexed display and captures each
// digit once its segment/anode pair has been stable for STABLE_CYCLES samples.
module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [3:0]  valid_mask,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t      state, next_state;
  logic [7:0]  cnt, next_cnt, cnt_inc;
  logic [3:0]  s_an, p_an;
  logic [6:0]  s_seg, p_seg;
  logic        changed, an_ok, capture;
  logic [1:0]  an_idx;
  logic [3:0]  code;

  // The previous pair resets to the same idle values as the sample pair, so
  // the first real sample after reset always counts as a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_an  <= 4'hF;
      s_seg <= 7'h7F;
      p_an  <= 4'hF;
      p_seg <= 7'h7F;
    end else begin
      s_an  <= an;
      s_seg <= seg;
      p_an  <= s_an;
      p_seg <= s_seg;
    end
  end

  always_comb begin
    case (s_seg)
      7'b0000001: code = 4'd0;
      7'b1001111: code = 4'd1;
      7'b0010010: code = 4'd2;
      7'b0000110: code = 4'd3;
      7'b1001100: code = 4'd4;
      7'b0100100: code = 4'd5;
      7'b0100000: code = 4'd6;
      7'b0001111: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0000100: code = 4'd9;
      7'b1111111: code = 4'hF;
      default:    code = 4'hE;
    endcase
  end

  always_comb begin
    an_ok  = 1'b1;
    an_idx = 2'd0;
    case (s_an)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_ok  = 1'b0;
    endcase
  end

  assign changed = (s_an != p_an) || (s_seg != p_seg);
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (changed) begin
      if (an_ok) begin
        next_cnt   = 8'd1;
        next_state = (STABLE == 8'd1) ? HELD : TRACK;
      end else begin
        next_cnt   = 8'd0;
        next_state = IDLE;
      end
    end else begin
      case (state)
        TRACK: begin
          next_cnt = cnt_inc;
          if (cnt_inc == STABLE)
            next_state = HELD;
        end
        default: ;
      endcase
    end
  end

  // Capture fires only on the transition into HELD, so a held pattern is
  // taken exactly once and a saturated counter can never retrigger it.
  always_comb begin
    capture = 1'b0;
    if (changed)
      capture = an_ok && (STABLE == 8'd1);
    else if (state == TRACK)
      capture = (cnt_inc == STABLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits     <= 16'hFFFF;
      valid_mask <= 4'h0;
      upd        <= 1'b0;
      upd_idx    <= 2'd0;
      err        <= 1'b0;
    end else begin
      upd <= capture;
      if (capture) begin
        digits[{an_idx, 2'b00} +: 4] <= code;
        valid_mask[an_idx]           <= 1'b1;
        upd_idx                      <= an_idx;
      end
      if (capture && code == 4'hE)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule
